// File: rtl/uart_hex_entry_if.sv
// uart_hex_entry_if: serial-in / display-word-out bundle for uart_hex_entry
//   i_RX        serial line into the receiver (idles high)
//   o_Data      last committed 16-bit hex value
//   o_Data_DV   one-cycle strobe when o_Data takes a new value
//   o_Frame_Err one-cycle strobe when a stop bit samples low
//   o_Digits    pending uncommitted digit count, 0..4
interface uart_hex_entry_if;
    logic        i_RX;
    logic [15:0] o_Data;
    logic        o_Data_DV;
    logic        o_Frame_Err;
    logic [2:0]  o_Digits;
    modport master (output i_RX, input o_Data, o_Data_DV, o_Frame_Err, o_Digits);
    modport slave  (input i_RX, output o_Data, o_Data_DV, o_Frame_Err, o_Digits);
endinterface

// File: rtl/uart_hex_entry.sv
// uart_hex_entry: 8N1 receiver parsing ASCII hex digits into a committed 16-bit word
//   i_Clk, i_Rst  clock and synchronous active-high reset
//   bus           uart_hex_entry_if.slave (i_RX in; o_Data, o_Data_DV, o_Frame_Err, o_Digits out)
module uart_hex_entry #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    uart_hex_entry_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [1:0]    vld_q, vld_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_dv_q, byte_dv_d;
    logic          ferr_q, ferr_d;
    logic          p_dv_q, p_dv_d;
    logic [15:0]   acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [15:0]   data_q, data_d;
    logic          data_dv_q, data_dv_d;

    logic       rx_s;
    logic       is_num, is_hex, is_eol, is_esc;
    logic [3:0] nib;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], bus.i_RX};
        // vld_q marks when the synchronizer holds real line samples rather than
        // its reset value, so a line held low across reset never arms the receiver
        vld_d     = {vld_q[0], 1'b1};
        armed_d   = armed_q | (vld_q[1] & rx_s);
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_dv_d = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_d     = '0;
                if (armed_q && !rx_s) state_d = START;
            end
            START: if (clk_cnt_q == HALF) begin
                clk_cnt_d = '0;
                state_d   = rx_s ? IDLE : DATA;
            end
            DATA: if (clk_cnt_q == FULL) begin
                clk_cnt_d = '0;
                shift_d   = {rx_s, shift_q[7:1]};
                bit_d     = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (clk_cnt_q == FULL) begin
                clk_cnt_d = '0;
                byte_dv_d = rx_s;
                ferr_d    = !rx_s;
                state_d   = CLEANUP;
            end
            CLEANUP: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The parser reads shift_q directly one cycle after the byte strobe; it cannot
    // change again until the next frame's first data bit, many cycles later.
    always_comb begin
        p_dv_d    = byte_dv_q;
        is_num    = shift_q >= 8'h30 && shift_q <= 8'h39;
        is_hex    = is_num || (shift_q >= 8'h41 && shift_q <= 8'h46) ||
                    (shift_q >= 8'h61 && shift_q <= 8'h66);
        is_eol    = shift_q == 8'h0D || shift_q == 8'h0A;
        is_esc    = shift_q == 8'h1B;
        nib       = is_num ? shift_q[3:0] : shift_q[3:0] + 4'd9;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        data_dv_d = 1'b0;
        if (p_dv_q) begin
            if (is_hex) begin
                acc_d = {acc_q[11:0], nib};
                cnt_d = cnt_q == 3'd4 ? 3'd4 : cnt_q + 3'd1;
            end else if (is_eol && cnt_q != 3'd0) begin
                data_d    = acc_q;
                data_dv_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else if (is_esc) begin
                acc_d = '0;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            vld_q     <= '0;
            armed_q   <= 1'b0;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            byte_dv_q <= 1'b0;
            ferr_q    <= 1'b0;
            p_dv_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            data_dv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            vld_q     <= vld_d;
            armed_q   <= armed_d;
            clk_cnt_q <= clk_cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            byte_dv_q <= byte_dv_d;
            ferr_q    <= ferr_d;
            p_dv_q    <= p_dv_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            data_dv_q <= data_dv_d;
        end
    end

    assign bus.o_Data      = data_q;
    assign bus.o_Data_DV   = data_dv_q;
    assign bus.o_Frame_Err = ferr_q;
    assign bus.o_Digits    = cnt_q;
endmodule

// File: doc/uart_hex_entry.md
Name: uart_hex_entry

Overview:
- Upstream feeder for the 16-bit seven-segment display driver: supplies the 16-bit word it scans out.
- Receives 8N1 serial characters on a single RX pin and parses ASCII hex digits into a 16-bit accumulator.
- On a line terminator, commits the accumulator to a held output word and pulses a one-cycle valid strobe.
- Also flags framing errors, giving the board an interactive "type a hex value, see it on the display" path.

Parameters:
- CLKS_PER_BIT, 104, system clocks per UART bit (12 MHz / 115200 ≈ 104); legal minimum 4.

Ports:
- i_Clk  input  1  system clock; all logic on posedge.
- i_Rst  input  1  synchronous, active-high reset.
- i_RX  input  1  asynchronous serial line; idles high.
- o_Data  output  16  last committed hex value; held between commits; feeds the display driver data input.
- o_Data_DV  output  1  one-cycle pulse in the cycle o_Data takes a new value.
- o_Frame_Err  output  1  one-cycle pulse when a received stop bit samples low.
- o_Digits  output  3  count of pending uncommitted digits, 0..4 (saturating).

Interface: one clock, i_Clk; i_Rst is synchronous, active-high.

Behaviour:
- Synchronizer: two flops on i_RX, both reset to 1; all logic uses the second-stage output (rx_s).
- Arming: after reset, the receiver ignores rx_s until it samples rx_s = 1 at least once.
  - A line held low through and after reset does not start a frame.
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: when armed and rx_s = 0 → START; bit counter = 0.
  - START: wait CLKS_PER_BIT/2 (integer divide) cycles, then re-sample. rx_s = 0 → DATA; rx_s = 1 → glitch, back to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first; → STOP after bit 7.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rx_s = 1: internal byte strobe (one cycle) with the byte.
    - rx_s = 0: o_Frame_Err pulses one cycle; byte discarded.
    - Either way → CLEANUP.
  - CLEANUP: one cycle → IDLE. A new start bit is accepted from IDLE at the earliest.
- Parser: acts in the cycle after the byte strobe. acc is 16 bits; cnt is 0..4.
  - '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66): acc ← {acc[11:0], nibble}; cnt ← min(cnt+1, 4).
  - More than 4 digits: oldest nibble shifted out; the last 4 digits win.
  - CR (0x0D) or LF (0x0A) with cnt > 0: o_Data ← acc; o_Data_DV = 1 for one cycle; acc ← 0; cnt ← 0.
  - CR/LF with cnt = 0: no commit, no pulse. A CR LF pair therefore commits once.
  - ESC (0x1B): acc ← 0; cnt ← 0; o_Data unchanged.
  - Any other byte: ignored.
- Fewer than 4 digits commit zero-extended: "2A" then CR gives o_Data = 0x002A.
- o_Digits = cnt at all times.
- Latency: o_Data_DV asserts exactly 2 cycles after the clock edge that samples the stop bit high.
- Reset (any state, including mid-frame):
  - FSM → IDLE, disarmed; acc = 0; cnt = 0.
  - o_Data = 0x0000; o_Data_DV = 0; o_Frame_Err = 0; o_Digits = 0.
  - A partially received byte is discarded and never strobed.
- Back-to-back frames (stop bit immediately followed by a start bit) are received without loss at the nominal baud rate.
- No backpressure: the consumer samples o_Data whenever it likes; o_Data_DV is informational.

Test Plan:
- CLKS_PER_BIT = 4; send "BEEF" then CR → o_Data = 0xBEEF, one o_Data_DV pulse 2 cycles after the CR stop-bit sample; o_Digits steps 1, 2, 3, 4, then 0.
- Send "12345" then LF → o_Data = 0x2345; o_Digits saturates at 4. Then send CR alone → no pulse, o_Data stays 0x2345.
- Send "ab" then ESC, then "7" and CR → o_Data = 0x0007, exactly one pulse; lowercase digits accepted.
- Send 0x41 with the stop bit driven low → o_Frame_Err pulses once; o_Digits stays 0. Next frame 'C' then CR → o_Data = 0x000C.
- Low pulse of CLKS_PER_BIT/2 − 1 cycles on an idle line → returns to IDLE; no byte, no error, o_Digits unchanged.
- Assert i_Rst in the middle of the DATA bits of '5' with RX held low → all outputs 0. Release reset with RX still low → no frame starts until RX goes high. Then send '9' and CR → o_Data = 0x0009.
